// File: rtl/fifo_rr_sched.sv
// Round-robin read scheduler over three FIFO read ports, merged onto one output stream.
// Each grant reads up to BURST words from one channel before the grant moves on.
module fifo_rr_sched #(
  parameter int DW    = 16,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdempty_a,
  input  logic          rdempty_b,
  input  logic          rdempty_c,
  input  logic [DW-1:0] q_a,
  input  logic [DW-1:0] q_b,
  input  logic [DW-1:0] q_c,
  output logic          rdreq_a,
  output logic          rdreq_b,
  output logic          rdreq_c,
  input  logic [2:0]    ch_en,
  output logic [DW-1:0] data_d,
  output logic          data_d_vld,
  output logic [1:0]    chan_d,
  output logic          busy
);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

  state_t     state, state_nxt;
  logic [1:0] cur, cur_nxt;
  logic [1:0] last, last_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       pend_vld;
  logic [1:0] pend_chan;

  logic [3:0] cand;
  logic [1:0] base, s1, s2, pick;
  logic       found, rd, burst_end;

  function automatic logic [1:0] nxt3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  always_comb begin
    // bit 3 pads the unreachable encoding cur==3 so it never reads as a candidate
    cand = {1'b0, ~rdempty_c & ch_en[2], ~rdempty_b & ch_en[1], ~rdempty_a & ch_en[0]};
    // the base channel itself is searched last, so a lone candidate can be re-granted
    base  = (state == ST_IDLE) ? last : cur;
    s1    = nxt3(base);
    s2    = nxt3(s1);
    found = cand[s1] | cand[s2] | cand[base];
    pick  = cand[s1] ? s1 : (cand[s2] ? s2 : base);

    rd        = (state == ST_BURST) && cand[cur];
    burst_end = !rd || (cnt == CNT_LAST);

    state_nxt = state;
    cur_nxt   = cur;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (found) begin
          cur_nxt   = pick;
          cnt_nxt   = '0;
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (rd) cnt_nxt = cnt + 4'd1;
        if (burst_end) begin
          last_nxt = cur;
          if (found) begin
            cur_nxt = pick;
            cnt_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      last      <= 2'd2;
      cur       <= 2'd0;
      cnt       <= '0;
      pend_vld  <= 1'b0;
      pend_chan <= 2'd0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      cur      <= cur_nxt;
      cnt      <= cnt_nxt;
      pend_vld <= rd;
      if (rd) pend_chan <= cur;
    end
  end

  // Outputs are masked by rst so the cycle carrying reset shows nothing pending.
  always_comb begin
    rdreq_a    = rd && !rst && (cur == 2'd0);
    rdreq_b    = rd && !rst && (cur == 2'd1);
    rdreq_c    = rd && !rst && (cur == 2'd2);
    busy       = (state == ST_BURST) && !rst;
    data_d_vld = pend_vld && !rst;
    chan_d     = rst ? 2'd0 : pend_chan;
    data_d     = '0;
    if (pend_vld && !rst) begin
      case (pend_chan)
        2'd0:    data_d = q_a;
        2'd1:    data_d = q_b;
        2'd2:    data_d = q_c;
        default: data_d = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed bench for fifo_rr_sched: queue-backed FIFO models, one BURST=4 and one BURST=2 instance.
module tb_fifo_rr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdempty_a, rdempty_b, rdempty_c;
  logic [15:0] q_a, q_b, q_c, data_d;
  logic        rdreq_a, rdreq_b, rdreq_c, data_d_vld, busy;
  logic [2:0]  ch_en;
  logic [1:0]  chan_d;

  logic        rst1, rdempty1_a, rdempty1_b, rdempty1_c;
  logic [15:0] q1_a, q1_b, q1_c, data1_d;
  logic        rdreq1_a, rdreq1_b, rdreq1_c, data1_d_vld, busy1;
  logic [1:0]  chan1_d;

  fifo_rr_sched #(.DW(16), .BURST(4)) u_dut (
    .clk(clk), .rst(rst),
    .rdempty_a(rdempty_a), .rdempty_b(rdempty_b), .rdempty_c(rdempty_c),
    .q_a(q_a), .q_b(q_b), .q_c(q_c),
    .rdreq_a(rdreq_a), .rdreq_b(rdreq_b), .rdreq_c(rdreq_c),
    .ch_en(ch_en), .data_d(data_d), .data_d_vld(data_d_vld),
    .chan_d(chan_d), .busy(busy)
  );

  fifo_rr_sched #(.DW(16), .BURST(2)) u_dut2 (
    .clk(clk), .rst(rst1),
    .rdempty_a(rdempty1_a), .rdempty_b(rdempty1_b), .rdempty_c(rdempty1_c),
    .q_a(q1_a), .q_b(q1_b), .q_c(q1_c),
    .rdreq_a(rdreq1_a), .rdreq_b(rdreq1_b), .rdreq_c(rdreq1_c),
    .ch_en(3'b111), .data_d(data1_d), .data_d_vld(data1_d_vld),
    .chan_d(chan1_d), .busy(busy1)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] fa[$], fb[$], fc[$];
  logic [1:0]  oc[$], oc1[$];
  logic [15:0] od[$], od1[$];

  int          cyc_n = 0, n_rd = 0;
  int          first_v = -1, last_v = -1, first_v1 = -1, last_v1 = -1;
  logic [2:0]  s_rd, s1_rd;
  logic        s_vld, s_busy;
  logic [15:0] s_data;
  logic [1:0]  s_chan;
  logic [15:0] ca1 = 16'd0, cc1 = 16'd0;

  logic [1:0]  exp_c1[6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
  logic [15:0] exp_d1[6] = '{16'hA000, 16'hA001, 16'hB000, 16'hB001, 16'hC000, 16'hC001};
  logic [1:0]  exp_c3[4] = '{2'd0, 2'd0, 2'd1, 2'd1};
  logic [15:0] exp_d3[4] = '{16'hA000, 16'hA001, 16'hB000, 16'hB001};
  logic [1:0]  exp_c4[6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
  logic [15:0] exp_d4[6] = '{16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hC002, 16'hC003};
  logic [1:0]  exp_c5[8] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2};
  logic [15:0] exp_d5[8] = '{16'hA100, 16'hA101, 16'hC100, 16'hC101,
                             16'hA102, 16'hA103, 16'hC102, 16'hC103};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock: sample outputs mid-cycle, then apply FIFO pops just after the edge.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    s_rd   = {rdreq_c, rdreq_b, rdreq_a};
    s_vld  = data_d_vld;
    s_data = data_d;
    s_chan = chan_d;
    s_busy = busy;
    check("onehot", 32'($countones(s_rd) <= 1), 32'd1);
    check("rd_while_empty", 32'(s_rd & {rdempty_c, rdempty_b, rdempty_a}), 32'd0);
    if (!s_vld) check("data_zero_idle", 32'(s_data), 32'd0);
    if (s_vld) begin
      oc.push_back(s_chan);
      od.push_back(s_data);
      if (first_v < 0) first_v = cyc_n;
      last_v = cyc_n;
    end
    n_rd += $countones(s_rd);

    s1_rd = {rdreq1_c, rdreq1_b, rdreq1_a};
    check("onehot_b2", 32'($countones(s1_rd) <= 1), 32'd1);
    check("rd_while_empty_b2", 32'(s1_rd & {rdempty1_c, rdempty1_b, rdempty1_a}), 32'd0);
    if (data1_d_vld) begin
      oc1.push_back(chan1_d);
      od1.push_back(data1_d);
      if (first_v1 < 0) first_v1 = cyc_n;
      last_v1 = cyc_n;
    end

    @(posedge clk);
    #1;
    if (s_rd[0]) begin if (fa.size() > 0) q_a = fa.pop_front(); else q_a = 16'hDEAD; end
    if (s_rd[1]) begin if (fb.size() > 0) q_b = fb.pop_front(); else q_b = 16'hDEAD; end
    if (s_rd[2]) begin if (fc.size() > 0) q_c = fc.pop_front(); else q_c = 16'hDEAD; end
    rdempty_a = (fa.size() == 0);
    rdempty_b = (fb.size() == 0);
    rdempty_c = (fc.size() == 0);
    if (s1_rd[0]) begin q1_a = 16'hA100 + ca1; ca1++; end
    if (s1_rd[2]) begin q1_c = 16'hC100 + cc1; cc1++; end
  endtask

  task automatic clear_log();
    oc.delete();
    od.delete();
    n_rd    = 0;
    first_v = -1;
    last_v  = -1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rdreq"}, 32'(s_rd), 32'd0);
    check({tag, "_vld"}, 32'(s_vld), 32'd0);
    check({tag, "_data"}, 32'(s_data), 32'd0);
    check({tag, "_chan"}, 32'(s_chan), 32'd0);
    check({tag, "_busy"}, 32'(s_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; ch_en = 3'b111;
    rdempty_a = 1'b1; rdempty_b = 1'b1; rdempty_c = 1'b1;
    q_a = '0; q_b = '0; q_c = '0;
    rst1 = 1'b1;
    rdempty1_a = 1'b0; rdempty1_b = 1'b1; rdempty1_c = 1'b0;
    q1_a = '0; q1_b = '0; q1_c = '0;

    // reset state
    cyc(); cyc();
    check_zero_outputs("in_reset");
    rst = 1'b0;
    cyc();
    check_zero_outputs("after_reset");

    // two words per FIFO, BURST=4: a,a,b,b,c,c
    fa = '{16'hA000, 16'hA001};
    fb = '{16'hB000, 16'hB001};
    fc = '{16'hC000, 16'hC001};
    rdempty_a = 1'b0; rdempty_b = 1'b0; rdempty_c = 1'b0;
    clear_log();
    for (int i = 0; i < 12; i++) cyc();
    check("t1_count", 32'(oc.size()), 32'd6);
    check("t1_reads", 32'(n_rd), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("t1_chan", (i < oc.size()) ? 32'(oc[i]) : 32'hFF, 32'(exp_c1[i]));
      check("t1_data", (i < od.size()) ? 32'(od[i]) : 32'hFFFF_FFFF, 32'(exp_d1[i]));
    end

    // all empty: stays idle
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_busy", 32'(s_busy), 32'd0);
      check("idle_rdreq", 32'(s_rd), 32'd0);
      check("idle_vld", 32'(s_vld), 32'd0);
    end

    // ten words on b only: back-to-back regrants, nothing read once empty
    for (int i = 0; i < 10; i++) fb.push_back(16'hB000 + 16'(i));
    rdempty_b = 1'b0;
    clear_log();
    for (int i = 0; i < 16; i++) cyc();
    check("t2_count", 32'(oc.size()), 32'd10);
    check("t2_reads", 32'(n_rd), 32'd10);
    check("t2_contig", 32'(last_v - first_v), 32'd9);
    for (int i = 0; i < 10; i++) begin
      check("t2_chan", (i < oc.size()) ? 32'(oc[i]) : 32'hFF, 32'd1);
      check("t2_data", (i < od.size()) ? 32'(od[i]) : 32'hFFFF_FFFF, 32'(16'hB000 + 16'(i)));
    end

    // ch_en[0] drops in the third read cycle of a burst on a
    fa.delete();
    for (int i = 0; i < 6; i++) fa.push_back(16'hA000 + 16'(i));
    fb = '{16'hB000, 16'hB001};
    rdempty_a = 1'b0; rdempty_b = 1'b0;
    clear_log();
    cyc(); cyc(); cyc();
    ch_en = 3'b110;
    cyc();
    check("t3_drop_noread", 32'(s_rd), 32'd0);
    for (int i = 0; i < 8; i++) cyc();
    check("t3_count", 32'(oc.size()), 32'd4);
    check("t3_vld_eq_rd", 32'(oc.size()), 32'(n_rd));
    for (int i = 0; i < 4; i++) begin
      check("t3_chan", (i < oc.size()) ? 32'(oc[i]) : 32'hFF, 32'(exp_c3[i]));
      check("t3_data", (i < od.size()) ? 32'(od[i]) : 32'hFFFF_FFFF, 32'(exp_d3[i]));
    end

    // mid-burst reset on c with a read pending; first grant afterwards goes to a
    ch_en = 3'b111;
    fc = '{16'hC000, 16'hC001, 16'hC002, 16'hC003};
    rdempty_c = 1'b0;
    clear_log();
    cyc(); cyc(); cyc();
    check("t4_pre_rd_c", 32'(s_rd), 32'd4);
    rst = 1'b1;
    cyc();
    check_zero_outputs("t4_rst");
    rst = 1'b0;
    clear_log();
    cyc();
    check("t4_post_vld", 32'(s_vld), 32'd0);
    check("t4_post_busy", 32'(s_busy), 32'd0);
    for (int i = 0; i < 12; i++) cyc();
    check("t4_count", 32'(oc.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("t4_chan", (i < oc.size()) ? 32'(oc[i]) : 32'hFF, 32'(exp_c4[i]));
      check("t4_data", (i < od.size()) ? 32'(od[i]) : 32'hFFFF_FFFF, 32'(exp_d4[i]));
    end

    // BURST=2 with a and c always non-empty: 0,0,2,2,... contiguous
    rst1 = 1'b0;
    for (int i = 0; i < 14; i++) cyc();
    check("t5_count", 32'(oc1.size()), 32'd12);
    check("t5_contig", 32'(last_v1 - first_v1 + 1), 32'(oc1.size()));
    for (int i = 0; i < 8; i++) begin
      check("t5_chan", (i < oc1.size()) ? 32'(oc1[i]) : 32'hFF, 32'(exp_c5[i]));
      check("t5_data", (i < od1.size()) ? 32'(od1[i]) : 32'hFFFF_FFFF, 32'(exp_d5[i]));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
